quadrilatero_rf_port: RTL

- Matrix register-file slice that serves the row-streamed read/write protocol driven by the systolic array, i.e. the responder end of that protocol.
- Holds N_REGS matrix registers of N_ROWS rows x RLEN bits.
- Provides one prefetching read port: one row/cycle after a 1-cycle start-up bubble.
- Provides one write port with read-after-write hazard tracking, so a consumer never receives stale rows of a register that is mid-write.

---
 rtl/quadrilatero_pkg.sv | 21 ++
 rtl/quadrilatero_rf_hazard_tracker.sv | 45 ++++
 rtl/quadrilatero_rf_port.sv | 104 ++++++++++
 3 files changed

// File: rtl/quadrilatero_pkg.sv
// Shared types for the matrix register-file slice.
package quadrilatero_pkg;

  // Wide enough for any register/row index used by the slice.
  localparam int RF_IDX_W = 8;

  // One row of one matrix register, used by the tag and fetch-address compares.
  typedef struct packed {
    logic [RF_IDX_W-1:0] rg;
    logic [RF_IDX_W-1:0] row;
  } rf_row_addr_t;

  function automatic rf_row_addr_t mk_row_addr(input logic [RF_IDX_W-1:0] rg,
                                               input logic [RF_IDX_W-1:0] row);
    rf_row_addr_t a;
    a.rg  = rg;
    a.row = row;
    return a;
  endfunction

endpackage

// File: rtl/quadrilatero_rf_hazard_tracker.sv
// Read-after-write hazard tracking: a register with a write in progress only
// exposes the rows that have already been rewritten.
module quadrilatero_rf_hazard_tracker #(
  parameter int N_REGS = 8,
  parameter int N_ROWS = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_acc,
  input  logic [$clog2(N_REGS)-1:0] waddr,
  input  logic [$clog2(N_ROWS)-1:0] wrowaddr,
  input  logic                      wlast,
  input  logic [$clog2(N_REGS)-1:0] raddr,
  input  logic [$clog2(N_ROWS)-1:0] rrowaddr,
  output logic                      hazard_ok,
  output logic [N_REGS-1:0]         busy
);

  logic [N_REGS-1:0] busy_q;
  logic [N_ROWS-1:0] written_q [N_REGS];
  logic [N_ROWS-1:0] row_onehot;

  assign row_onehot = {{(N_ROWS-1){1'b0}}, 1'b1} << wrowaddr;
  assign hazard_ok  = ~busy_q[raddr] | written_q[raddr][rrowaddr];
  assign busy       = busy_q;

  // Track which registers are mid-write and which of their rows are fresh.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      for (int i = 0; i < N_REGS; i++) written_q[i] <= '0;
    end else if (wr_acc) begin
      if (wlast) begin
        busy_q[waddr]    <= 1'b0;
        written_q[waddr] <= '0;
      end else if (!busy_q[waddr]) begin
        busy_q[waddr]    <= 1'b1;
        written_q[waddr] <= row_onehot;
      end else begin
        written_q[waddr] <= written_q[waddr] | row_onehot;
      end
    end
  end

endmodule

// File: rtl/quadrilatero_rf_port.sv
// Matrix register-file slice: responder end of the row-streamed protocol.
// Handshake: a row transfers in a cycle where rvalid_o & rready_i are both 1;
// rvalid_o may depend combinationally on the request inputs, and a write
// transfers in a cycle where we_i & wready_o are both 1.
module quadrilatero_rf_port
  import quadrilatero_pkg::*;
#(
  parameter int N_REGS     = 8,
  parameter int MESH_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [$clog2(N_REGS)-1:0]        raddr_i,
  input  logic [$clog2(MESH_WIDTH)-1:0]    rrowaddr_i,
  input  logic                             rready_i,
  input  logic                             rlast_i,
  output logic [DATA_WIDTH*MESH_WIDTH-1:0] rdata_o,
  output logic                             rvalid_o,
  input  logic [$clog2(N_REGS)-1:0]        waddr_i,
  input  logic [$clog2(MESH_WIDTH)-1:0]    wrowaddr_i,
  input  logic [DATA_WIDTH*MESH_WIDTH-1:0] wdata_i,
  input  logic                             we_i,
  input  logic                             wlast_i,
  output logic                             wready_o,
  output logic [N_REGS-1:0]                busy_o
);

  localparam int N_ROWS = MESH_WIDTH;
  localparam int RLEN   = DATA_WIDTH * MESH_WIDTH;
  localparam int RR_W   = $clog2(N_ROWS);

  logic [RLEN-1:0] mem [N_REGS][N_ROWS];
  logic [RLEN-1:0] rbuf_q;
  logic [RLEN-1:0] fetch_data;
  rf_row_addr_t    tag_q, req_addr, fetch_addr, wr_addr;
  logic            tag_vld_q;
  logic            wready_q, wr_acc;
  logic            hazard_ok, rvalid, handshake, fwd;
  logic [RR_W-1:0] next_row, fetch_row;

  assign wr_acc   = we_i & wready_q;
  assign req_addr = mk_row_addr(RF_IDX_W'(raddr_i), RF_IDX_W'(rrowaddr_i));
  assign wr_addr  = mk_row_addr(RF_IDX_W'(waddr_i), RF_IDX_W'(wrowaddr_i));

  assign rvalid    = tag_vld_q & (tag_q == req_addr) & hazard_ok;
  assign handshake = rvalid & rready_i & ~rlast_i;

  // Prefetch the following row (wrapping) once the current one is consumed.
  assign next_row   = (rrowaddr_i == RR_W'(N_ROWS - 1)) ? '0 : rrowaddr_i + RR_W'(1);
  assign fetch_row  = handshake ? next_row : rrowaddr_i;
  assign fetch_addr = mk_row_addr(RF_IDX_W'(raddr_i), RF_IDX_W'(fetch_row));

  // A write landing on the fetched row is forwarded so the buffer is never stale.
  assign fwd        = wr_acc & (wr_addr == fetch_addr);
  assign fetch_data = fwd ? wdata_i : mem[raddr_i][fetch_row];

  assign rvalid_o = rvalid;
  assign rdata_o  = rvalid ? rbuf_q : '0;
  assign wready_o = wready_q;

  // Write port is always ready once out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wready_q <= 1'b0;
    else         wready_q <= 1'b1;
  end

  // Row storage; contents intentionally survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[waddr_i][wrowaddr_i] <= wdata_i;
  end

  // One-row read buffer with tag; invalidated when its row is overwritten.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rbuf_q    <= '0;
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
    end else if (rready_i) begin
      rbuf_q    <= fetch_data;
      tag_q     <= fetch_addr;
      tag_vld_q <= 1'b1;
    end else if (wr_acc && (wr_addr == tag_q)) begin
      tag_vld_q <= 1'b0;
    end
  end

  quadrilatero_rf_hazard_tracker #(
    .N_REGS (N_REGS),
    .N_ROWS (N_ROWS)
  ) u_hazard (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .wr_acc   (wr_acc),
    .waddr    (waddr_i),
    .wrowaddr (wrowaddr_i),
    .wlast    (wlast_i),
    .raddr    (raddr_i),
    .rrowaddr (rrowaddr_i),
    .hazard_ok(hazard_ok),
    .busy     (busy_o)
  );

endmodule
